// File: rtl/vram_write_scheduler.sv
// Single-port VRAM write sequencer for the text terminal: character FIFO, cursor, newline row clear, scroll base.
// Optional full-screen clear is built only when VRAM_SCHED_SCREEN_CLEAR_EN is defined.
module vram_write_scheduler #(
   parameter int         COLS       = 40,
   parameter int         ROWS       = 24,
   parameter int         FIFO_DEPTH = 8,
   parameter logic [5:0] CLR_CHAR   = 6'd32
) (
   input  logic        clk25,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        w_en,
   input  logic [7:0]  din,
   input  logic        clear_req,
   output logic        rdy,
   output logic        busy,
   output logic        overflow,
   output logic [10:0] vram_w_addr,
   output logic [5:0]  vram_din,
   output logic        vram_w_en,
   output logic [5:0]  h_cursor,
   output logic [4:0]  v_cursor,
   output logic [4:0]  vram_start_addr
);
   // state      | meaning
   // IDLE       | wait for pending clear or FIFO entry, pop and decode
   // WRITE      | emit the decoded glyph at the cursor, advance column
   // CLR_LINE   | fill row v_cursor with CLR_CHAR, one column per cycle
   // CLR_SCREEN | fill all 32 physical rows, then home cursor and scroll base
   typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_SCREEN} state_t;

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [5:0] LAST_COL = 6'(COLS - 1);
   localparam logic [4:0] ROWS_5   = 5'(ROWS);

   state_t        state, state_nxt;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          seen, full, cap, push, pop, nl, ovf_clr;
   logic [7:0]    head;
   logic [5:0]    char_q, char_nxt, col_cnt, col_nxt, h_nxt, data_nxt;
   logic [4:0]    v_nxt, start_nxt;
   logic [10:0]   addr_nxt;
   logic          we_nxt;
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
   logic          pending, pend_take;
   logic [4:0]    row_cnt, row_nxt;
`else
   logic          unused_clear;
   assign unused_clear = clear_req;
`endif

   assign full = (count == FULL_CNT);
   assign cap  = enable & w_en & ~seen;
   assign push = cap & ~full;
   assign head = fifo_mem[rptr];
   assign rdy  = ~full;
   assign busy = (state != IDLE) | (count != '0) | vram_w_en;

   always_comb begin
      state_nxt = state;
      h_nxt     = h_cursor;
      v_nxt     = v_cursor;
      start_nxt = vram_start_addr;
      col_nxt   = col_cnt;
      char_nxt  = char_q;
      we_nxt    = 1'b0;
      addr_nxt  = vram_w_addr;
      data_nxt  = vram_din;
      pop       = 1'b0;
      nl        = 1'b0;
      ovf_clr   = 1'b0;
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
      pend_take = 1'b0;
      row_nxt   = row_cnt;
`endif
      case (state)
         IDLE: begin
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
            if (pending) begin
               pend_take = 1'b1;
               row_nxt   = 5'd0;
               col_nxt   = 6'd0;
               state_nxt = CLR_SCREEN;
            end else
`endif
            if (count != '0) begin
               pop = 1'b1;
               if (head == 8'h8D) begin
                  nl = 1'b1;
               end else if (head == 8'h7F) begin
                  h_nxt = 6'd0;
               end else begin
                  char_nxt  = {~head[6], head[4:0]};
                  state_nxt = WRITE;
               end
            end
         end
         WRITE: begin
            we_nxt   = 1'b1;
            addr_nxt = {v_cursor, h_cursor};
            data_nxt = char_q;
            if (h_cursor == LAST_COL) begin
               nl = 1'b1;
            end else begin
               h_nxt     = h_cursor + 6'd1;
               state_nxt = IDLE;
            end
         end
         CLR_LINE: begin
            we_nxt   = 1'b1;
            addr_nxt = {v_cursor, col_cnt};
            data_nxt = CLR_CHAR;
            col_nxt  = col_cnt + 6'd1;
            if (col_cnt == LAST_COL) begin
               col_nxt   = 6'd0;
               state_nxt = IDLE;
            end
         end
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
         CLR_SCREEN: begin
            we_nxt   = 1'b1;
            addr_nxt = {row_cnt, col_cnt};
            data_nxt = CLR_CHAR;
            col_nxt  = col_cnt + 6'd1;
            if (col_cnt == LAST_COL) begin
               col_nxt = 6'd0;
               row_nxt = row_cnt + 5'd1;
               if (row_cnt == 5'd31) begin
                  h_nxt     = 6'd0;
                  v_nxt     = 5'd0;
                  start_nxt = 5'd0;
                  ovf_clr   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
      // Scroll when the new cursor row lands ROWS rows below the top of screen.
      if (nl) begin
         h_nxt   = 6'd0;
         v_nxt   = v_cursor + 5'd1;
         col_nxt = 6'd0;
         if (5'(v_nxt - vram_start_addr) == ROWS_5)
            start_nxt = vram_start_addr + 5'd1;
         state_nxt = CLR_LINE;
      end
   end

   always_ff @(posedge clk25) begin
      if (push)
         fifo_mem[wptr] <= din;
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         wptr            <= '0;
         rptr            <= '0;
         count           <= '0;
         seen            <= 1'b0;
         overflow        <= 1'b0;
         char_q          <= 6'd0;
         col_cnt         <= 6'd0;
         h_cursor        <= 6'd0;
         v_cursor        <= 5'd0;
         vram_start_addr <= 5'd0;
         vram_w_en       <= 1'b0;
         vram_w_addr     <= 11'd0;
         vram_din        <= 6'd0;
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
         pending         <= 1'b0;
         row_cnt         <= 5'd0;
`endif
      end else begin
         state           <= state_nxt;
         char_q          <= char_nxt;
         col_cnt         <= col_nxt;
         h_cursor        <= h_nxt;
         v_cursor        <= v_nxt;
         vram_start_addr <= start_nxt;
         vram_w_en       <= we_nxt;
         vram_w_addr     <= addr_nxt;
         vram_din        <= data_nxt;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (cap)
            seen <= 1'b1;
         else if (!enable && !w_en)
            seen <= 1'b0;
         if (cap && full)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
         row_cnt <= row_nxt;
         if (clear_req)
            pending <= 1'b1;
         else if (pend_take)
            pending <= 1'b0;
`endif
      end
   end
endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench for vram_write_scheduler: expected VRAM writes are queued and checked as the DUT emits them.
module tb_vram_write_scheduler;
   logic        clk25, rst_n, enable, w_en, clear_req;
   logic [7:0]  din;
   logic        rdy, busy, overflow, vram_w_en;
   logic [10:0] vram_w_addr;
   logic [5:0]  vram_din, h_cursor;
   logic [4:0]  v_cursor, vram_start_addr;

   int errors = 0;
   int checks = 0;
   logic [16:0] exp_q[$];

   vram_write_scheduler dut (
      .clk25(clk25), .rst_n(rst_n), .enable(enable), .w_en(w_en), .din(din),
      .clear_req(clear_req), .rdy(rdy), .busy(busy), .overflow(overflow),
      .vram_w_addr(vram_w_addr), .vram_din(vram_din), .vram_w_en(vram_w_en),
      .h_cursor(h_cursor), .v_cursor(v_cursor), .vram_start_addr(vram_start_addr)
   );

   initial clk25 = 1'b0;
   always #20 clk25 = ~clk25;

   // Glyph mapping of the TX byte: {~d[6], d[4:0]}.
   function automatic logic [5:0] glyph(input logic [7:0] d);
      logic [5:0] g;
      g[5]   = ~d[6];
      g[4:0] = d[4:0];
      return g;
   endfunction

   function automatic logic [16:0] wr(input int row, input int col, input logic [5:0] data);
      logic [4:0] r;
      logic [5:0] c;
      r = 5'(row);
      c = 6'(col);
      return {r, c, data};
   endfunction

   always @(negedge clk25) begin
      if (rst_n && vram_w_en) begin
         logic [16:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h din=%h, expected no write", vram_w_addr, vram_din);
         end else begin
            e = exp_q.pop_front();
            if ({vram_w_addr, vram_din} !== e) begin
               errors++;
               $display("FAIL vram_write: got addr=%h din=%h, expected addr=%h din=%h",
                        vram_w_addr, vram_din, e[16:6], e[5:0]);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0; w_en = 1'b0; din = 8'h00; clear_req = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk25);
      rst_n = 1'b1;
      @(negedge clk25);
   endtask

   task automatic strobe(input logic [7:0] c);
      enable = 1'b1; w_en = 1'b1; din = c;
      @(negedge clk25);
      enable = 1'b0; w_en = 1'b0;
      @(negedge clk25);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 5000) begin
         @(negedge clk25);
         n++;
      end
      checks++;
      if (n >= 5000) begin
         errors++;
         $display("FAIL %s_timeout: busy=%b pending_writes=%0d, expected idle within 5000 cycles",
                  name, busy, exp_q.size());
      end
   endtask

   task automatic check_pos(input string name, input logic [5:0] h, input logic [4:0] v, input logic [4:0] s);
      checks++;
      if ({h_cursor, v_cursor, vram_start_addr} !== {h, v, s}) begin
         errors++;
         $display("FAIL %s: got h=%0d v=%0d start=%0d, expected h=%0d v=%0d start=%0d",
                  name, h_cursor, v_cursor, vram_start_addr, h, v, s);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0; w_en = 1'b0; din = 8'h00; clear_req = 1'b0;
      repeat (2) @(negedge clk25);
      checks++;
      if ({rdy, busy, overflow, vram_w_en} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags: got rdy=%b busy=%b ovf=%b we=%b, expected 1 0 0 0", rdy, busy, overflow, vram_w_en);
      end
      checks++;
      if ({vram_w_addr, vram_din} !== 17'd0) begin
         errors++;
         $display("FAIL reset_bus: got addr=%h din=%h, expected 0 0", vram_w_addr, vram_din);
      end
      check_pos("reset_cursor", 6'd0, 5'd0, 5'd0);
      rst_n = 1'b1;
      @(negedge clk25);
   endtask

   task automatic test_single_char();
      do_reset();
      exp_q.push_back(wr(0, 0, 6'h01));
      strobe(8'hC1);
      repeat (3) @(negedge clk25);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: got busy=%b, expected 0", busy);
      end
      check_pos("single_cursor", 6'd1, 5'd0, 5'd0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_write: got %0d writes outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic test_line_wrap();
      do_reset();
      for (int c = 0; c < 40; c++) exp_q.push_back(wr(0, c, glyph(8'hC1)));
      for (int c = 0; c < 40; c++) exp_q.push_back(wr(1, c, 6'd32));
      for (int i = 0; i < 40; i++) strobe(8'hC1);
      wait_idle("wrap");
      check_pos("wrap_cursor", 6'd0, 5'd1, 5'd0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL wrap_overflow: got %b, expected 0", overflow);
      end
   endtask

   task automatic test_scroll();
      do_reset();
      for (int k = 1; k <= 23; k++) begin
         for (int c = 0; c < 40; c++) exp_q.push_back(wr(k, c, 6'd32));
         strobe(8'h8D);
         wait_idle("scroll_nl");
      end
      check_pos("scroll_23", 6'd0, 5'd23, 5'd0);
      for (int c = 0; c < 40; c++) exp_q.push_back(wr(24, c, 6'd32));
      strobe(8'h8D);
      wait_idle("scroll_24");
      check_pos("scroll_24", 6'd0, 5'd24, 5'd1);
   endtask

   task automatic test_overflow();
      do_reset();
      for (int c = 0; c < 40; c++) exp_q.push_back(wr(1, c, 6'd32));
      for (int i = 0; i < 8; i++) exp_q.push_back(wr(1, i, glyph(8'(8'hB0 + i))));
      strobe(8'h8D);
      for (int i = 0; i < 8; i++) strobe(8'(8'hB0 + i));
      checks++;
      if ({rdy, overflow} !== 2'b00) begin
         errors++;
         $display("FAIL ovf_full: got rdy=%b ovf=%b, expected rdy=0 ovf=0", rdy, overflow);
      end
      strobe(8'hB8);
      checks++;
      if ({rdy, overflow} !== 2'b01) begin
         errors++;
         $display("FAIL ovf_drop: got rdy=%b ovf=%b, expected rdy=0 ovf=1", rdy, overflow);
      end
      wait_idle("ovf");
      check_pos("ovf_cursor", 6'd8, 5'd1, 5'd0);
   endtask

   task automatic test_back_to_back_del();
      do_reset();
      for (int i = 0; i < 5; i++) exp_q.push_back(wr(0, i, glyph(8'(8'hC1 + i))));
      for (int i = 0; i < 5; i++) strobe(8'(8'hC1 + i));
      wait_idle("b2b");
      check_pos("b2b_cursor", 6'd5, 5'd0, 5'd0);
      strobe(8'h7F);
      wait_idle("del");
      repeat (3) @(negedge clk25);
      check_pos("del_cursor", 6'd0, 5'd0, 5'd0);
   endtask

   task automatic test_clear_screen();
      do_reset();
      for (int c = 0; c < 40; c++) exp_q.push_back(wr(1, c, 6'd32));
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 40; c++) exp_q.push_back(wr(r, c, 6'd32));
      for (int i = 0; i < 8; i++) exp_q.push_back(wr(0, i, glyph(8'(8'hC1 + i))));
`else
      for (int i = 0; i < 8; i++) exp_q.push_back(wr(1, i, glyph(8'(8'hC1 + i))));
`endif
      strobe(8'h8D);
      clear_req = 1'b1;
      @(negedge clk25);
      clear_req = 1'b0;
      for (int i = 0; i < 9; i++) strobe(8'(8'hC1 + i));
      wait_idle("clr");
`ifdef VRAM_SCHED_SCREEN_CLEAR_EN
      check_pos("clr_cursor", 6'd8, 5'd0, 5'd0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL clr_overflow: got %b, expected 0", overflow);
      end
`else
      check_pos("clr_cursor", 6'd8, 5'd1, 5'd0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL clr_overflow: got %b, expected 1", overflow);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_char();
      test_line_wrap();
      test_scroll();
      test_overflow();
      test_back_to_back_del();
      test_clear_screen();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
